rob_ptr_ctrl: RTL
=================

# rob_ptr_ctrl

Reorder-buffer pointer and occupancy controller that sits directly downstream of dispatch. It allocates ROB indices (with wrap flag) to instructions leaving dispatch, retires them at the head on commit, and rolls the enqueue pointer back on a redirect flush. It produces the `counter`, `enq_robidx_flag` and `enq_robidx` values that dispatch uses for back-pressure and for tagging instructions.

## Interface
Parameters:
- `ROB_SIZE_LOG`, 6, log2 of ROB entry count; `ROB_SIZE = 2**ROB_SIZE_LOG`.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enq0_valid`  in  1  dispatch instr0 handshake completed this cycle (valid & ready).
- `enq1_valid`  in  1  dispatch instr1 handshake completed; legal only with `enq0_valid`.
- `commit0_valid`  in  1  head entry retires.
- `commit1_valid`  in  1  head+1 entry retires; legal only with `commit0_valid`.
- `flush_valid`  in  1  redirect flush.
- `flush_robidx_flag`  in  1  wrap flag of the flushing instruction.
- `flush_robidx`  in  ROB_SIZE_LOG  index of the flushing instruction. This instruction is kept; everything younger is discarded.
- `enq_robidx_flag`, `enq_robidx`  out  1, ROB_SIZE_LOG  slot for instr0.
- `enq1_robidx_flag`, `enq1_robidx`  out  1, ROB_SIZE_LOG  slot for instr1 (`enq + 1`, wrapped).
- `deq_robidx_flag`, `deq_robidx`  out  1, ROB_SIZE_LOG  oldest live entry.
- `counter`  out  ROB_SIZE_LOG+1  live entry count, 0..ROB_SIZE.
- `full`  out  1  `counter == ROB_SIZE`.
- `empty`  out  1  `counter == 0`.
- `can_enq2`  out  1  `counter <= ROB_SIZE-2`.
- `err`  out  1  sticky protocol-error flag.

## Operation
- State consists of the enqueue pointer `{enq_flag, enq_idx}` and the dequeue pointer `{deq_flag, deq_idx}`. All pointers are ROB_SIZE_LOG+1 bits. Incrementing past ROB_SIZE-1 wraps the index to 0 and toggles the flag.
- `counter` is held in a register and always equals the pointer distance:
  - flags equal: `enq_idx - deq_idx`;
  - flags differ: `ROB_SIZE - deq_idx + enq_idx`.
- Enqueue amount is `n_enq = enq0_valid + enq1_valid`, and the enqueue pointer advances by `n_enq`.
  - An enqueue that would exceed ROB_SIZE (after counting same-cycle commits) is dropped entirely. No pointer moves and `err` is set.
  - `enq1_valid` without `enq0_valid` sets `err` and is treated as `n_enq = 0`.
- Commit amount is `n_cmt = commit0_valid + commit1_valid`, and the dequeue pointer advances by `n_cmt`.
  - A commit exceeding `counter` is dropped and sets `err`.
  - `commit1_valid` without `commit0_valid` sets `err` and is treated as `n_cmt = 0`.
- Simultaneous enqueue and commit both apply: `counter_next = counter + n_enq - n_cmt`. Enqueue capacity is evaluated on `counter - n_cmt`, so a full ROB that commits 1 accepts 1 enqueue in the same cycle.
- Flush:
  - Enqueue is ignored in a flush cycle, regardless of `enq*_valid`.
  - Commit still applies.
  - `enq_ptr_next = {flush_robidx_flag, flush_robidx} + 1`, wrapped.
  - `counter_next` is recomputed from `deq_ptr_next` and `enq_ptr_next`.
  - The flush target must lie in the occupied window `[deq_ptr, enq_ptr)` after commit. A flush of a just-committed entry, or a target outside the window, sets `err` and leaves `enq_ptr` unchanged.
- `err` clears only on reset.

## Timing
- All outputs are driven from registers or from pure functions of registers. There is no combinational path from any input to any output.
- Pointer, counter and flag updates are visible one cycle after the triggering input (1-cycle latency).
- A slot returned in cycle N is the slot consumed by an enqueue in cycle N. Dispatch samples `enq_robidx*` in the same cycle it asserts the handshake.
- Reset (asynchronous, any time, including mid-flush) forces:
  - all pointers and flags to 0;
  - `counter=0`, `empty=1`, `full=0`, `can_enq2=1`, `err=0`;
  - `enq1_robidx=1`, `enq1_robidx_flag=0`.
- Normal operation resumes on the first rising edge after `reset_n` deasserts.
- Boundary behaviour:
  - Full: enqueue is dropped unless a same-cycle commit frees space.
  - Empty: commit is dropped and sets `err`.
  - Wrap at index ROB_SIZE-1 toggles the flag; a dual enqueue at ROB_SIZE-1 yields `enq1_robidx=0` with the toggled flag.

## Test plan
- **Reset, then single enqueues:** 3 cycles of `enq0_valid` → `enq_robidx` 0,1,2, then 3; `counter=3`; `empty=0`.
- **Dual enqueue across wrap** (ROB_SIZE=64, `enq_ptr` at 63, flag 0): `enq0`+`enq1` → slots {0,63} and {1,0}; next `enq_robidx=1`, flag=1.
- **Fill to 64 entries:** `full=1`; a further `enq0` → dropped and `err=1`. Separately, when full, `enq0`+`commit0` in the same cycle → `counter` stays 64, both pointers +1, `err=0`.
- **Flush rollback** (deq=5, enq=20, flags 0): flush idx 9 with `commit0` in the same cycle → `enq=10`, `deq=6`, `counter=4`. Same-cycle `enq0_valid` is ignored.
- **Flush across flag boundary** (deq={0,60}, enq={1,4}): flush {0,62} → `enq={0,63}`, `counter=3`. Flush {1,2} → `enq={1,3}`, `counter=7`.
- **Asynchronous reset mid-operation** (`counter=10`, `reset_n` low between edges): outputs go to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer pointer/occupancy controller: allocates ROB slots at dispatch,
// retires them on commit and rolls the enqueue pointer back on a redirect flush.
module rob_ptr_ctrl #(
  parameter int ROB_SIZE_LOG = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enq0_valid,
  input  logic                    enq1_valid,
  input  logic                    commit0_valid,
  input  logic                    commit1_valid,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  output logic                    enq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] enq_robidx,
  output logic                    enq1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] enq1_robidx,
  output logic                    deq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] deq_robidx,
  output logic [ROB_SIZE_LOG:0]   counter,
  output logic                    full,
  output logic                    empty,
  output logic                    can_enq2,
  output logic                    err
);

  localparam int PW = ROB_SIZE_LOG + 1;
  localparam int CW = ROB_SIZE_LOG + 2;
  localparam logic [CW-1:0] ROB_SIZE_C = CW'(2 ** ROB_SIZE_LOG);

  logic [PW-1:0] enq_ptr_r;
  logic [PW-1:0] deq_ptr_r;
  logic [PW-1:0] counter_r;
  logic          err_r;

  logic [PW-1:0] enq_ptr_next_s;
  logic [PW-1:0] deq_ptr_next_s;
  logic [PW-1:0] counter_next_s;
  logic          err_set_s;
  logic [1:0]    n_enq_s;
  logic [1:0]    n_cmt_s;
  logic          enq_bad_s;
  logic          cmt_bad_s;
  logic          cmt_drop_s;
  logic          enq_drop_s;
  logic          flush_ok_s;
  logic [CW-1:0] cnt_after_cmt_s;
  logic [CW-1:0] enq_sum_s;
  logic [PW-1:0] flush_tgt_s;
  logic [PW-1:0] flush_dist_s;
  logic [PW-1:0] enq1_ptr_s;

  // Next-state computation: commit first, then flush or enqueue against the post-commit occupancy.
  always_comb begin
    enq_bad_s = enq1_valid & ~enq0_valid;
    cmt_bad_s = commit1_valid & ~commit0_valid;

    if (enq_bad_s) begin
      n_enq_s = 2'd0;
    end else begin
      n_enq_s = 2'(enq0_valid) + 2'(enq1_valid);
    end

    if (cmt_bad_s) begin
      n_cmt_s = 2'd0;
    end else begin
      n_cmt_s = 2'(commit0_valid) + 2'(commit1_valid);
    end

    cmt_drop_s = (CW'(counter_r) < CW'(n_cmt_s));
    if (cmt_drop_s) begin
      n_cmt_s = 2'd0;
    end else begin
      n_cmt_s = n_cmt_s;
    end

    cnt_after_cmt_s = CW'(counter_r) - CW'(n_cmt_s);
    deq_ptr_next_s  = deq_ptr_r + PW'(n_cmt_s);

    // Distance from the new head; a target is live only if it sits below the post-commit count.
    flush_tgt_s  = {flush_robidx_flag, flush_robidx};
    flush_dist_s = flush_tgt_s - deq_ptr_next_s;
    flush_ok_s   = (CW'(flush_dist_s) < cnt_after_cmt_s);

    enq_sum_s  = cnt_after_cmt_s + CW'(n_enq_s);
    enq_drop_s = (n_enq_s != 2'd0) && (enq_sum_s > ROB_SIZE_C);

    err_set_s = enq_bad_s | cmt_bad_s | cmt_drop_s;

    if (flush_valid) begin
      if (flush_ok_s) begin
        enq_ptr_next_s = flush_tgt_s + PW'(1);
        counter_next_s = flush_dist_s + PW'(1);
      end else begin
        enq_ptr_next_s = enq_ptr_r;
        counter_next_s = PW'(cnt_after_cmt_s);
        err_set_s      = 1'b1;
      end
    end else if (enq_drop_s) begin
      enq_ptr_next_s = enq_ptr_r;
      counter_next_s = PW'(cnt_after_cmt_s);
      err_set_s      = 1'b1;
    end else begin
      enq_ptr_next_s = enq_ptr_r + PW'(n_enq_s);
      counter_next_s = PW'(enq_sum_s);
    end
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_r <= {PW{1'b0}};
      deq_ptr_r <= {PW{1'b0}};
      counter_r <= {PW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      enq_ptr_r <= enq_ptr_next_s;
      deq_ptr_r <= deq_ptr_next_s;
      counter_r <= counter_next_s;
      err_r     <= err_r | err_set_s;
    end
  end

  assign enq1_ptr_s = enq_ptr_r + PW'(1);

  assign enq_robidx_flag  = enq_ptr_r[PW-1];
  assign enq_robidx       = enq_ptr_r[ROB_SIZE_LOG-1:0];
  assign enq1_robidx_flag = enq1_ptr_s[PW-1];
  assign enq1_robidx      = enq1_ptr_s[ROB_SIZE_LOG-1:0];
  assign deq_robidx_flag  = deq_ptr_r[PW-1];
  assign deq_robidx       = deq_ptr_r[ROB_SIZE_LOG-1:0];
  assign counter          = counter_r;
  assign full             = (CW'(counter_r) == ROB_SIZE_C);
  assign empty            = (counter_r == {PW{1'b0}});
  assign can_enq2         = (CW'(counter_r) <= (ROB_SIZE_C - CW'(2)));
  assign err              = err_r;

endmodule
